uart_rx_frame: RTL and testbench

- UART receive framing stage, directly upstream of the receive parity checker.
- Oversamples the synchronized serial line and detects the start bit with glitch rejection.
- Deserializes DWIDTH data bits LSB-first and captures the optional parity bit.
- Checks the stop bit. Presents p_data, sampled_bit and a one-cycle parity_check_en to the checker, plus data_valid and stop_error to the RX top.

---
 rtl/uart_rx_frame.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receive framing: start-bit detection with glitch rejection, LSB-first deserialization,
// optional parity capture and stop-bit check. Define UART_RX_MAJORITY_VOTE_EN for 3-sample bit voting.
module uart_rx_frame #(
  parameter int DWIDTH     = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              parity_en,
  output logic [DWIDTH-1:0] p_data,
  output logic              sampled_bit,
  output logic              parity_check_en,
  output logic              data_valid,
  output logic              stop_error,
  output logic              busy
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [EW-1:0] E_ONE  = EW'(1);
  localparam logic [EW-1:0] E_LAST = EW'(OVERSAMPLE - 1);
  localparam logic [EW-1:0] E_MID  = EW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] C_LAST = CW'(DWIDTH - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [EW-1:0] E_EARLY = EW'(OVERSAMPLE / 2 - 1);
  localparam logic [EW-1:0] E_VOTE  = EW'(OVERSAMPLE / 2 + 1);
  localparam logic [EW-1:0] E_EXIT  = EW'(OVERSAMPLE / 2 + 2);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic s_early_q, s_early_d;
  logic s_mid_q, s_mid_d;
`else
  localparam logic [EW-1:0] E_EXIT = EW'(OVERSAMPLE / 2 + 1);
`endif

  logic [2:0]        state_q, state_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              bit_q, bit_d;
  logic              par_en_q, par_en_d;
  logic [DWIDTH-1:0] p_data_q, p_data_d;
  logic              sampled_q, sampled_d;
  logic              pce_q, pce_d;
  logic              dv_q, dv_d;
  logic              se_q, se_d;
  logic              busy_q, busy_d;
  logic              wrap_s;

  assign wrap_s = (edge_q == E_LAST);

  // Next-state logic: bit sampling, edge/bit counters, FSM and strobes
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    bit_cnt_d = bit_cnt_q;
    bit_d     = bit_q;
    par_en_d  = par_en_q;
    p_data_d  = p_data_q;
    sampled_d = sampled_q;
    pce_d     = 1'b0;
    dv_d      = 1'b0;
    se_d      = 1'b0;

`ifdef UART_RX_MAJORITY_VOTE_EN
    s_early_d = s_early_q;
    s_mid_d   = s_mid_q;
    if (edge_q == E_EARLY) begin
      s_early_d = rx_in;
    end else if (edge_q == E_MID) begin
      s_mid_d = rx_in;
    end else if (edge_q == E_VOTE) begin
      bit_d = maj3(s_early_q, s_mid_q, rx_in);
    end else begin
      bit_d = bit_q;
    end
`else
    if (edge_q == E_MID) begin
      bit_d = rx_in;
    end else begin
      bit_d = bit_q;
    end
`endif

    if (state_q != IDLE) begin
      edge_d = wrap_s ? '0 : edge_q + E_ONE;
    end else begin
      edge_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d   = START;
          edge_d    = E_ONE;
          bit_cnt_d = '0;
          par_en_d  = parity_en;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        // A high mid-bit sample means the low pulse was a glitch, not a start bit
        if ((edge_q == E_EXIT) && bit_q) begin
          state_d = IDLE;
          edge_d  = '0;
        end else if (wrap_s) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (wrap_s) begin
          p_data_d[bit_cnt_q] = bit_q;
          if (bit_cnt_q == C_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + C_ONE;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (wrap_s) begin
          sampled_d = bit_q;
          pce_d     = 1'b1;
          state_d   = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (wrap_s) begin
          dv_d    = bit_q;
          se_d    = ~bit_q;
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d   = IDLE;
        edge_d    = '0;
        bit_cnt_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      edge_q    <= '0;
      bit_cnt_q <= '0;
      bit_q     <= 1'b1;
      par_en_q  <= 1'b0;
      p_data_q  <= '0;
      sampled_q <= 1'b0;
      pce_q     <= 1'b0;
      dv_q      <= 1'b0;
      se_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      s_early_q <= 1'b1;
      s_mid_q   <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_cnt_q <= bit_cnt_d;
      bit_q     <= bit_d;
      par_en_q  <= par_en_d;
      p_data_q  <= p_data_d;
      sampled_q <= sampled_d;
      pce_q     <= pce_d;
      dv_q      <= dv_d;
      se_q      <= se_d;
      busy_q    <= busy_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
      s_early_q <= s_early_d;
      s_mid_q   <= s_mid_d;
`endif
    end
  end

  assign p_data          = p_data_q;
  assign sampled_bit     = sampled_q;
  assign parity_check_en = pce_q;
  assign data_valid      = dv_q;
  assign stop_error      = se_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame (DWIDTH 8, OVERSAMPLE 8); cycle 0 is start-bit edge 0.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       parity_en;
  logic [7:0] p_data;
  logic       sampled_bit;
  logic       parity_check_en;
  logic       data_valid;
  logic       stop_error;
  logic       busy;

  int total = 0;
  int bad   = 0;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int         GX         = 7;
  localparam logic [7:0] GLITCH_EXP = 8'hFF;
`else
  localparam int         GX         = 6;
  localparam logic [7:0] GLITCH_EXP = 8'hFB;
`endif

  logic       wave   [0:299];
  logic       busy_w [0:299];
  int         dv_n, dv_at, pce_n, pce_at, se_n, se_at, ovl_n;
  logic [7:0] pd_dv, pd_pce;
  logic       sb_pce;

  uart_rx_frame #(.DWIDTH(8), .OVERSAMPLE(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_in           (rx_in),
    .parity_en       (parity_en),
    .p_data          (p_data),
    .sampled_bit     (sampled_bit),
    .parity_check_en (parity_check_en),
    .data_valid      (data_valid),
    .stop_error      (stop_error),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_idle();
    for (int i = 0; i < 300; i++) wave[i] = 1'b1;
  endtask

  task automatic add_frame(input int s, input logic [7:0] d, input bit pe, input bit pb, input bit sb);
    logic v;
    for (int b = 0; b <= 9 + int'(pe); b++) begin
      if (b == 0) v = 1'b0;
      else if (b <= 8) v = d[b-1];
      else if (pe && b == 9) v = pb;
      else v = sb;
      for (int e = 0; e < 8; e++) wave[s + 8*b + e] = v;
    end
  endtask

  // Called at posedge+1; cycle c drives wave[c] and observes outputs at the negedge of cycle c.
  task automatic play(input int ncyc);
    dv_n = 0; dv_at = -1; pce_n = 0; pce_at = -1; se_n = 0; se_at = -1; ovl_n = 0;
    pd_dv = 8'h00; pd_pce = 8'h00; sb_pce = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      rx_in = wave[c];
      @(negedge clk);
      busy_w[c] = busy;
      if (data_valid) begin
        if (dv_n == 0) dv_at = c;
        pd_dv = p_data;
        dv_n++;
      end
      if (parity_check_en) begin
        if (pce_n == 0) pce_at = c;
        pd_pce = p_data;
        sb_pce = sampled_bit;
        pce_n++;
      end
      if (stop_error) begin
        if (se_n == 0) se_at = c;
        se_n++;
      end
      if (data_valid && stop_error) ovl_n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; rx_in = 1'b1; parity_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_pdata", p_data, 8'h00);
    chk("rst_dv", data_valid, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Idle line
    fill_idle();
    play(50);
    chk("idle_busy", busy_w[49], 1'b0);
    chk("idle_pdata", p_data, 8'h00);
    chk("idle_strobes", dv_n + pce_n + se_n, 0);
    chk("idle_sb", sampled_bit, 1'b0);

    // 0xA5, no parity
    parity_en = 1'b0;
    fill_idle(); add_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    play(100);
    chk("a5_dv_n", dv_n, 1);
    chk("a5_dv_at", dv_at, 80);
    chk("a5_pdata", pd_dv, 8'hA5);
    chk("a5_pce_n", pce_n, 0);
    chk("a5_se_n", se_n, 0);
    chk("a5_busy_start", busy_w[1], 1'b1);
    chk("a5_busy_end", busy_w[80], 1'b0);

    // 0x3C with parity bit 0
    parity_en = 1'b1;
    fill_idle(); add_frame(0, 8'h3C, 1'b1, 1'b0, 1'b1);
    play(100);
    chk("3c_pce_n", pce_n, 1);
    chk("3c_pce_at", pce_at, 80);
    chk("3c_pce_pdata", pd_pce, 8'h3C);
    chk("3c_sb", sb_pce, 1'b0);
    chk("3c_dv_at", dv_at, 88);
    chk("3c_dv_n", dv_n, 1);

    // 0x01 with parity bit 1
    fill_idle(); add_frame(0, 8'h01, 1'b1, 1'b1, 1'b1);
    play(100);
    chk("01_pce_at", pce_at, 80);
    chk("01_sb", sb_pce, 1'b1);
    chk("01_dv_at", dv_at, 88);
    chk("01_pdata", pd_dv, 8'h01);

    // Three-cycle low glitch on an idle line
    parity_en = 1'b0;
    fill_idle(); wave[0] = 1'b0; wave[1] = 1'b0; wave[2] = 1'b0;
    play(20);
    chk("gl_busy_before", busy_w[GX-1], 1'b1);
    chk("gl_busy_drop", busy_w[GX], 1'b0);
    chk("gl_strobes", dv_n + pce_n + se_n, 0);
    chk("gl_pdata", p_data, 8'h01);

    // Stop error on 0x55, then 0x0F back-to-back from cycle 80
    fill_idle();
    add_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    add_frame(80, 8'h0F, 1'b0, 1'b0, 1'b1);
    play(170);
    chk("se_n", se_n, 1);
    chk("se_at", se_at, 80);
    chk("se_dv_n", dv_n, 1);
    chk("b2b_dv_at", dv_at, 160);
    chk("b2b_pdata", pd_dv, 8'h0F);
    chk("se_overlap", ovl_n, 0);

    // Reset asserted mid-frame at cycle 30
    fill_idle(); add_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    play(30);
    rst = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_pdata", p_data, 8'h00);
    chk("mrst_strobes", {data_valid, stop_error, parity_check_en}, 3'b000);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    fill_idle();
    play(5);
    chk("mrst_idle_strobes", dv_n + pce_n + se_n, 0);
    add_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    play(90);
    chk("ff_dv_at", dv_at, 80);
    chk("ff_pdata", pd_dv, 8'hFF);

    // One-cycle low glitch at mid-bit of data bit 2
    fill_idle(); add_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    wave[28] = 1'b0;
    play(90);
    chk("vote_dv_at", dv_at, 80);
    chk("vote_pdata", pd_dv, GLITCH_EXP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
